// File: rtl/bootram_pkg.sv
// Shared definitions for the boot-RAM arbiter slice: default widths and the
// port-select enum used by the arbiter and the response pipeline.
package bootram_pkg;

  localparam int BOOTRAM_ADDR_W = 4;
  localparam int BOOTRAM_DATA_W = 32;

  typedef enum logic {
    PORT_P0 = 1'b0,
    PORT_P1 = 1'b1
  } port_sel_e;

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-way round-robin arbiter. Grants are combinational from the requests;
// the last-granted pointer moves only when a grant is issued, so a requester
// that withdraws without being granted leaves the arbitration order intact.
module bootram_rr_arb
  import bootram_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic p0_req,
  input  logic p1_req,
  output logic p0_gnt,
  output logic p1_gnt
);

  port_sel_e last_q;

  // Exactly one grant under contention: the port that did not win last time.
  assign p0_gnt = !rst_i && p0_req && (!p1_req || (last_q == PORT_P1));
  assign p1_gnt = !rst_i && p1_req && (!p0_req || (last_q == PORT_P0));

  // Track the most recent winner; reset favours p0 on the first contention.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of the order of statements or blocks.
    if (rst_i) begin
      last_q <= PORT_P1;
    end else if (p0_gnt) begin
      last_q <= PORT_P0;
    end else if (p1_gnt) begin
      last_q <= PORT_P1;
    end
  end

endmodule

// File: rtl/bootram_arb.sv
// Boot-RAM arbiter: shares a single-port boot RAM between an instruction-fetch
// reader (p0) and a loader/data port (p1), returning read data one cycle after
// each grant. Optional write-lock is enabled by defining
// BOOTRAM_ARB_WRITE_LOCK_EN; once locked, p1 writes are absorbed and flagged.
module bootram_arb
  import bootram_pkg::*;
#(
  parameter int ADDR_W = BOOTRAM_ADDR_W,
  parameter int DATA_W = BOOTRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction-fetch requester (read-only)
  input  logic              p0_req_i,
  input  logic [31:0]       p0_addr_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  // loader/data requester (read-write)
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              p1_err_o,
  // write-lock
  input  logic              lock_i,
  output logic              locked_o,
  // boot-RAM port (registered read data)
  output logic              ram_req_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  logic      p0_gnt;
  logic      p1_gnt;
  logic      locked_q;
  logic      resp_valid_q;
  port_sel_e resp_port_q;
  logic      resp_err_q;
  logic      resp_deliver;

  bootram_rr_arb u_rr_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .p0_req (p0_req_i),
    .p1_req (p1_req_i),
    .p0_gnt (p0_gnt),
    .p1_gnt (p1_gnt)
  );

  assign p0_gnt_o  = p0_gnt;
  assign p1_gnt_o  = p1_gnt;
  assign ram_req_o = p0_gnt | p1_gnt;

  // Steer the RAM command from whichever port holds the grant.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    ram_addr_o  = p0_addr_i[ADDR_W+1:2];
    ram_wen_o   = 1'b0;
    ram_wdata_o = '0;
    if (p1_gnt) begin
      ram_addr_o  = p1_addr_i[ADDR_W+1:2];
      ram_wen_o   = p1_we_i & ~locked_q;
      ram_wdata_o = p1_wdata_i;
    end
  end

  // Remember who was granted so the returning RAM word is routed to them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= PORT_P0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= ram_req_o;
      resp_port_q  <= p1_gnt ? PORT_P1 : PORT_P0;
      resp_err_q   <= p1_gnt & p1_we_i & locked_q;
    end
  end

`ifdef BOOTRAM_ARB_WRITE_LOCK_EN
  // Sticky lock: set by a lock pulse, cleared only by reset. A write granted
  // alongside the pulse still sees the old (unlocked) value and goes through.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
    end else if (lock_i) begin
      locked_q <= 1'b1;
    end
  end
`else
  assign locked_q = 1'b0;
`endif

  assign locked_o = locked_q;

  // A response still in flight when reset rises is never presented.
  assign resp_deliver = resp_valid_q & ~rst_i;
  assign p0_rvalid_o  = resp_deliver && (resp_port_q == PORT_P0);
  assign p1_rvalid_o  = resp_deliver && (resp_port_q == PORT_P1);
  assign p0_rdata_o   = p0_rvalid_o ? ram_rdata_i : '0;
  assign p1_rdata_o   = p1_rvalid_o ? ram_rdata_i : '0;
  assign p1_err_o     = p1_rvalid_o & resp_err_q;

  // Address bits outside the word index carry no meaning for this RAM.
  logic unused_ok;
  assign unused_ok = ^{lock_i,
                       p0_addr_i[31:ADDR_W+2], p0_addr_i[1:0],
                       p1_addr_i[31:ADDR_W+2], p1_addr_i[1:0]};

endmodule

// File: tb/tb_bootram_arb.sv
// Directed self-checking bench for bootram_arb with a behavioural boot RAM
// (registered read, read-before-write). Covers both builds of the write-lock.
module tb_bootram_arb;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              p0_req, p1_req, p1_we, lock;
  logic [31:0]       p0_addr, p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p1_err, locked;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              ram_req, ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_cmp = 0;
  int n_err = 0;

  bootram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .p0_req_i    (p0_req),
    .p0_addr_i   (p0_addr),
    .p0_gnt_o    (p0_gnt),
    .p0_rvalid_o (p0_rvalid),
    .p0_rdata_o  (p0_rdata),
    .p1_req_i    (p1_req),
    .p1_we_i     (p1_we),
    .p1_addr_i   (p1_addr),
    .p1_wdata_i  (p1_wdata),
    .p1_gnt_o    (p1_gnt),
    .p1_rvalid_o (p1_rvalid),
    .p1_rdata_o  (p1_rdata),
    .p1_err_o    (p1_err),
    .lock_i      (lock),
    .locked_o    (locked),
    .ram_req_o   (ram_req),
    .ram_wen_o   (ram_wen),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read returns the pre-write word one cycle later.
  always @(posedge clk) begin
    if (ram_req) begin
      ram_rdata <= mem[ram_addr];
      if (ram_wen) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0;
    p1_req = 1'b0;
    p1_we  = 1'b0;
    lock   = 1'b0;
  endtask

  initial begin
    // NOTE: the RAM array has no reset; its contents are preloaded once here.
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA000_0000 + i;
    ram_rdata = '0;
    rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b0; lock = 1'b0;
    p0_addr = '0; p1_addr = '0; p1_wdata = '0;

    // Reset holds grants low even with both ports requesting.
    #2;
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_p1_gnt", p1_gnt, 0);
    check("rst_ram_req", ram_req, 0);
    tick();
    check("rst_p0_rvalid", p0_rvalid, 0);
    check("rst_p1_rvalid", p1_rvalid, 0);
    check("rst_locked", locked, 0);
    check("rst_p1_err", p1_err, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    rst = 1'b0; idle();
    #1;
    check("idle_ram_req", ram_req, 0);

    // p0 read of 0x8 -> word 2, grant now, data next cycle.
    p0_req = 1'b1; p0_addr = 32'h0000_0008;
    #1;
    check("rd8_p0_gnt", p0_gnt, 1);
    check("rd8_p1_gnt", p1_gnt, 0);
    check("rd8_ram_req", ram_req, 1);
    check("rd8_ram_addr", ram_addr, 2);
    check("rd8_ram_wen", ram_wen, 0);
    tick();
    p0_req = 1'b0;
    check("rd8_p0_rvalid", p0_rvalid, 1);
    check("rd8_p0_rdata", p0_rdata, 32'hA000_0002);
    check("rd8_p1_rvalid", p1_rvalid, 0);
    check("rd8_p1_rdata", p1_rdata, 0);

    // Upper address bits ignored: 0xFFFF_FFC4 -> word 1.
    p0_req = 1'b1; p0_addr = 32'hFFFF_FFC4;
    #1;
    check("hi_ram_addr", ram_addr, 1);
    tick();
    p0_req = 1'b0;
    check("hi_p0_rdata", p0_rdata, 32'hA000_0001);

    // Fresh reset, then 4 cycles of contention: P0, P1, P0, P1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h0000_0004;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_000C;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_p0_gnt", p0_gnt, (k % 2 == 0));
      check("cont_p1_gnt", p1_gnt, (k % 2 == 1));
      tick();
      check("cont_p0_rvalid", p0_rvalid, (k % 2 == 0));
      check("cont_p1_rvalid", p1_rvalid, (k % 2 == 1));
      check("cont_p0_rdata", p0_rdata, (k % 2 == 0) ? 32'hA000_0001 : 32'h0);
      check("cont_p1_rdata", p1_rdata, (k % 2 == 1) ? 32'hA000_0003 : 32'h0);
    end
    idle();

    // p1 writes 0xDEADBEEF to 0x10, then p0 reads it back on the next cycle.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0010; p1_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_p1_gnt", p1_gnt, 1);
    check("wr_ram_wen", ram_wen, 1);
    check("wr_ram_addr", ram_addr, 4);
    check("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    tick();
    check("wr_p1_rvalid", p1_rvalid, 1);
    check("wr_p1_err", p1_err, 0);
    check("wr_p1_rdata_old", p1_rdata, 32'hA000_0004);
    idle();
    p0_req = 1'b1; p0_addr = 32'h0000_0010;
    #1;
    check("wrrd_p0_gnt", p0_gnt, 1);
    tick();
    idle();
    check("wrrd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);

`ifdef BOOTRAM_ARB_WRITE_LOCK_EN
    // Write granted alongside the lock pulse still lands.
    lock = 1'b1;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0014; p1_wdata = 32'h5555_AAAA;
    #1;
    check("lk_same_wen", ram_wen, 1);
    tick();
    lock = 1'b0;
    check("lk_locked", locked, 1);
    check("lk_same_err", p1_err, 0);
    // Locked write: granted, memory untouched, error flagged.
    p1_addr = 32'h0000_0000; p1_wdata = 32'h1234_5678;
    #1;
    check("lk_p1_gnt", p1_gnt, 1);
    check("lk_ram_wen", ram_wen, 0);
    tick();
    idle();
    check("lk_p1_rvalid", p1_rvalid, 1);
    check("lk_p1_err", p1_err, 1);
    p0_req = 1'b1; p0_addr = 32'h0000_0000;
    tick();
    check("lk_rd0", p0_rdata, 32'hA000_0000);
    p0_addr = 32'h0000_0014;
    tick();
    idle();
    check("lk_rd14", p0_rdata, 32'h5555_AAAA);
`else
    // Without the feature, lock_i is ignored and writes always pass.
    lock = 1'b1;
    tick();
    lock = 1'b0;
    check("nolk_locked", locked, 0);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h0000_0000; p1_wdata = 32'h1234_5678;
    #1;
    check("nolk_ram_wen", ram_wen, 1);
    tick();
    idle();
    check("nolk_p1_rvalid", p1_rvalid, 1);
    check("nolk_p1_err", p1_err, 0);
    p0_req = 1'b1; p0_addr = 32'h0000_0000;
    tick();
    idle();
    check("nolk_rd0", p0_rdata, 32'h1234_5678);
`endif

    // Reset in the cycle after a p0 grant drops that response.
    p0_req = 1'b1; p0_addr = 32'h0000_0008;
    #1;
    check("rr_p0_gnt", p0_gnt, 1);
    tick();
    rst = 1'b1; p0_req = 1'b0;
    #1;
    check("rr_p0_rvalid_masked", p0_rvalid, 0);
    tick();
    check("rr_p0_rvalid", p0_rvalid, 0);
    check("rr_locked", locked, 0);
    rst = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h0000_0004;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h0000_000C;
    #1;
    check("rr_cont_p0_gnt", p0_gnt, 1);
    check("rr_cont_p1_gnt", p1_gnt, 0);
    tick();
    idle();
    check("rr_cont_p0_rvalid", p0_rvalid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
